// File: rtl/omega_ctrl_pkg.sv
// Shared types and sizing for the omega evaluation controller.
package omega_ctrl_pkg;

    localparam int NUM_GRP_DEF = 16;
    localparam int GRP_W       = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/omega_grp_cnt.sv
// Group index counter for the omega evaluation controller: clear, increment, hold.
module omega_grp_cnt
    import omega_ctrl_pkg::*;
#(
    parameter int NUM_GRP = NUM_GRP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [GRP_W-1:0] o_grp_idx,
    output logic             o_grp_last
);

    localparam logic [GRP_W-1:0] LAST_IDX = GRP_W'(NUM_GRP - 1);

    logic [GRP_W-1:0] r_idx;

    // Clear wins over increment; the index saturates so it never leaves the codeword.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc && (r_idx != LAST_IDX)) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_grp_idx  = r_idx;
    assign o_grp_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/omega_eval_ctrl.sv
// Omega evaluation controller: steps the datapath through NUM_GRP sum groups per codeword.
// Optional abort input enabled by defining OMEGA_EVAL_CTRL_ABORT_EN.
module omega_eval_ctrl
    import omega_ctrl_pkg::*;
#(
    parameter int NUM_GRP = NUM_GRP_DEF
) (
    input  logic             clk,
    input  logic             reset,
`ifdef OMEGA_EVAL_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    output logic             start_ready,
    output logic             ld_sel,
    output logic             eval_en,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [GRP_W-1:0] grp_idx,
    output logic             grp_last,
    output logic             busy
);

    state_t r_state;
    logic   r_idle;
    logic   r_busy;
    logic   r_sumValid;

    logic   w_abort;
    logic   w_accept;
    logic   w_runAdv;
    logic   w_runDone;
    logic   w_grpLast;

`ifdef OMEGA_EVAL_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Handshake qualifiers are gated by reset so nothing leaks to the datapath while held.
    assign start_ready = reset & r_idle & ~w_abort;
    assign w_accept    = start_ready & start;
    assign w_runAdv    = reset & r_busy & ~w_abort & sum_ready & ~w_grpLast;
    assign w_runDone   = r_busy & (w_abort | (sum_ready & w_grpLast));

    assign ld_sel    = w_accept;
    assign eval_en   = w_accept | w_runAdv;
    assign sum_valid = r_sumValid;
    assign busy      = r_busy;
    assign grp_last  = w_grpLast;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_idle     <= 1'b1;
            r_busy     <= 1'b0;
            r_sumValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_RUN;
                        r_idle     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_sumValid <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_runDone) begin
                        r_state    <= S_IDLE;
                        r_idle     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_sumValid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_idle     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_sumValid <= 1'b0;
                end
            endcase
        end
    end

    omega_grp_cnt #(
        .NUM_GRP (NUM_GRP)
    ) u_grp_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_accept | w_runDone),
        .i_inc      (w_runAdv),
        .o_grp_idx  (grp_idx),
        .o_grp_last (w_grpLast)
    );

endmodule

// File: tb/tb_omega_eval_ctrl.sv
// Self-checking bench for omega_eval_ctrl: directed scenarios plus random traffic,
// run against a 16-group and a 2-group instance fed with identical inputs.
module tb_omega_eval_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, sumReady, abort;

    logic       srA, ldA, enA, svA, lastA, busyA;
    logic [3:0] grpA;
    logic       srB, ldB, enB, svB, lastB, busyB;
    logic [3:0] grpB;

    int checks = 0;
    int errors = 0;

    // Abstract model: is a codeword in flight, and which group is on the sums.
    typedef struct {
        bit busy;
        int grp;
    } mdl_t;

    mdl_t mA, mB;

    omega_eval_ctrl #(.NUM_GRP(16)) dutA (
        .clk         (clk),
        .reset       (reset),
`ifdef OMEGA_EVAL_CTRL_ABORT_EN
        .abort       (abort),
`endif
        .start       (start),
        .start_ready (srA),
        .ld_sel      (ldA),
        .eval_en     (enA),
        .sum_valid   (svA),
        .sum_ready   (sumReady),
        .grp_idx     (grpA),
        .grp_last    (lastA),
        .busy        (busyA)
    );

    omega_eval_ctrl #(.NUM_GRP(2)) dutB (
        .clk         (clk),
        .reset       (reset),
`ifdef OMEGA_EVAL_CTRL_ABORT_EN
        .abort       (abort),
`endif
        .start       (start),
        .start_ready (srB),
        .ld_sel      (ldB),
        .eval_en     (enB),
        .sum_valid   (svB),
        .sum_ready   (sumReady),
        .grp_idx     (grpB),
        .grp_last    (lastB),
        .busy        (busyB)
    );

    // Expected {start_ready, ld_sel, eval_en, sum_valid, grp_last, busy} for this cycle.
    function automatic logic [5:0] expFlags(mdl_t m, int n, logic rst, logic st, logic sr, logic ab);
        logic rdy, acc, en;
        rdy = rst && !m.busy && !ab;
        acc = rdy && st;
        en  = acc || (rst && m.busy && !ab && sr && (m.grp < n - 1));
        return {rdy, acc, en, logic'(m.busy), logic'(m.grp == n - 1), logic'(m.busy)};
    endfunction

    function automatic mdl_t nextModel(mdl_t m, int n, logic rst, logic st, logic sr, logic ab);
        mdl_t r;
        r = m;
        if (!rst) begin
            r.busy = 1'b0;
            r.grp  = 0;
        end else if (!m.busy) begin
            if (st && !ab) begin
                r.busy = 1'b1;
                r.grp  = 0;
            end
        end else if (ab || (sr && m.grp == n - 1)) begin
            r.busy = 1'b0;
            r.grp  = 0;
        end else if (sr) begin
            r.grp = m.grp + 1;
        end
        return r;
    endfunction

    task automatic expect6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances against the model, away from the clock edge.
    task automatic checkOutput();
        expect6("flags_n16", {srA, ldA, enA, svA, lastA, busyA},
                expFlags(mA, 16, reset, start, sumReady, abort));
        expect4("grp_n16", grpA, 4'(mA.grp));
        expect6("flags_n2", {srB, ldB, enB, svB, lastB, busyB},
                expFlags(mB, 2, reset, start, sumReady, abort));
        expect4("grp_n2", grpB, 4'(mB.grp));
    endtask

    // Drive one cycle of inputs, check at the falling edge, advance the model at the rising edge.
    task automatic applyStimulus(input logic rst, input logic st, input logic sr, input logic ab);
        reset    = rst;
        start    = st;
        sumReady = sr;
        abort    = ab;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        mA = nextModel(mA, 16, rst, st, sr, ab);
        mB = nextModel(mB, 2, rst, st, sr, ab);
        #1;
    endtask

    task automatic drainRun(input logic st);
        for (int i = 0; i < 24 && busyA; i++) applyStimulus(1'b1, st, 1'b1, 1'b0);
        expect4("drain_idle", {3'b000, busyA}, 4'd0);
    endtask

    initial begin
        mA = '{busy: 1'b0, grp: 0};
        mB = '{busy: 1'b0, grp: 0};
        reset = 1'b0; start = 1'b0; sumReady = 1'b1; abort = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

        // Full unstalled codeword: accept, 16 groups, idle at accept+17.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            expect4("walk_grp", grpA, 4'(k));
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        end
        expect4("walk_done_busy", {3'b000, busyA}, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        // Stall at group 3 for five cycles.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            expect4("stall_grp", grpA, 4'd3);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        expect4("resume_grp", grpA, 4'd4);
        drainRun(1'b0);

        // Start held high through a run is ignored, then accepted right after the bubble.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        expect4("mid_start_grp", grpA, 4'd7);
        drainRun(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        expect4("reaccept_busy", {3'b000, busyA}, 4'd1);

        // Reset pulse at group 9 discards the codeword.
        for (int k = 0; k < 9; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        expect4("pre_reset_grp", grpA, 4'd9);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        expect4("post_reset_grp", grpA, 4'd0);
        expect4("post_reset_sv", {3'b000, svA}, 4'd0);

`ifdef OMEGA_EVAL_CTRL_ABORT_EN
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        expect4("abort_busy", {3'b000, busyA}, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        expect4("abort_idle_start", {3'b000, busyA}, 4'd0);
`endif

        // Random traffic with occasional reset pulses and stalls.
        for (int i = 0; i < 600; i++) begin
            logic rr, ss, rd, ab;
            rr = ($urandom_range(0, 40) != 0);
            ss = $urandom_range(0, 1) == 1;
            rd = ($urandom_range(0, 3) != 0);
            ab = 1'b0;
`ifdef OMEGA_EVAL_CTRL_ABORT_EN
            ab = ($urandom_range(0, 15) == 0);
`endif
            applyStimulus(rr, ss, rd, ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/omega_eval_ctrl.md
OMEGA_EVAL_CTRL -- requirements
Module: omega_eval_ctrl

Interface
REQ-001 Parameter: NUM_GRP, default 16, number of 16-position evaluation groups per codeword; legal range 2..16.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  reset; one clock; reset is synchronous and active-low.
REQ-004 Port: start  in  1  omega coefficients are valid on the datapath inputs this cycle.
REQ-005 Port: start_ready  out  1  controller can accept start.
REQ-006 Port: ld_sel  out  1  drives the datapath coefficient/feedback mux; 1 selects the omega coefficients.
REQ-007 Port: eval_en  out  1  drives the datapath register enable.
REQ-008 Port: sum_valid  out  1  the datapath sum registers hold a valid group.
REQ-009 Port: sum_ready  in  1  downstream consumes the current group.
REQ-010 Port: grp_idx  out  4  index of the group currently on the sums, 0..NUM_GRP-1.
REQ-011 Port: grp_last  out  1  the current group is NUM_GRP-1.
REQ-012 Port: busy  out  1  a codeword evaluation is in progress.

Function
REQ-013 States SHALL be IDLE and RUN; start_ready = (state==IDLE); busy = (state==RUN).
REQ-014 accept = start & start_ready; on accept, ld_sel=1 and eval_en=1 in the same cycle (combinational from start); next state RUN, grp_idx=0.
REQ-015 ld_sel SHALL be 1 only in an accept cycle and 0 in all other cycles.
REQ-016 In RUN, sum_valid=1; eval_en = sum_ready & ~grp_last.
REQ-017 RUN with sum_ready=1 and grp_last=0: grp_idx increments next cycle, and the new sums are valid one cycle after eval_en.
REQ-018 RUN with sum_ready=0: eval_en=0 and grp_idx, sum_valid and the datapath sums hold (stall) for any number of cycles.
REQ-019 RUN with sum_ready=1 and grp_last=1: eval_en=0; next state IDLE, sum_valid=0, grp_idx=0.
REQ-020 start in RUN SHALL be ignored; start_ready is 1 no earlier than the cycle after the last group is consumed (one-cycle bubble).
REQ-021 Unstalled latency: accept at cycle T gives group k valid at T+1+k; the codeword occupies NUM_GRP+1 cycles from accept to return to IDLE.
REQ-022 grp_idx SHALL never exceed NUM_GRP-1; grp_last = (grp_idx==NUM_GRP-1).

Reset
REQ-023 While reset=0 at a clock edge: state=IDLE, grp_idx=0, sum_valid=0, busy=0.
REQ-024 While reset=0, eval_en=0, ld_sel=0 and start_ready=0 combinationally; start is ignored.
REQ-025 Reset asserted mid-RUN SHALL discard the codeword with no further eval_en pulse; the datapath sums are reset by the same net.
REQ-026 First accept is possible in the first cycle with reset=1.

Configuration
REQ-027 Macro OMEGA_EVAL_CTRL_ABORT_EN: when defined, adds input port abort (1 bit); abort=1 in RUN forces eval_en=0, next state IDLE, sum_valid=0, grp_idx=0, with priority over sum_ready.
REQ-028 With abort=1 in IDLE, start_ready=0 and start is not accepted.
REQ-029 Without the macro, the abort port is absent and behaviour is exactly REQ-013..REQ-026.

Structure
REQ-030 Package omega_ctrl_pkg SHALL hold the state enum, the NUM_GRP default (16) and GRP_W=4.
REQ-031 Sub-module omega_grp_cnt SHALL implement the group counter (clear, increment, hold, grp_last); the FSM stays in omega_eval_ctrl.

Verification
REQ-032 Reset release, start=1 in the next cycle with sum_ready held at 1 -> ld_sel=eval_en=1 in that cycle; grp_idx 0..15 on 16 consecutive cycles; grp_last=1 only at grp_idx 15; back in IDLE at accept+17.
REQ-033 sum_ready=0 for 5 cycles at grp_idx=3 -> eval_en=0, grp_idx=3 and sum_valid=1 held for 5 cycles; resumes with 4 on the next cycle.
REQ-034 start pulsed at grp_idx=7 -> ignored, start_ready=0; start_ready=1 the cycle after group 15 is consumed; a start there is accepted.
REQ-035 reset=0 for one cycle at grp_idx=9 -> next cycle IDLE, sum_valid=0, grp_idx=0, no eval_en pulse during reset.
REQ-036 Abort macro defined, abort=1 at grp_idx=5 with sum_ready=1 -> eval_en=0 that cycle, IDLE next cycle; abort=1 with start=1 in IDLE -> not accepted.
REQ-037 NUM_GRP=2 -> grp_last=1 at grp_idx 1; the codeword completes in 3 cycles unstalled.
